// File: rtl/lfpm_share_arbiter.sv
// Round-robin scheduler that shares one approximate log FP16 multiplier among NREQ requesters.
// Optional WAIT watchdog enabled by defining LFPM_TIMEOUT_EN (result becomes qNaN with rsp_err=1).
module lfpm_share_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [15:0]        rsp_data,
    output logic               rsp_err,
    output logic               mul_start,
    output logic [15:0]        mul_a,
    output logic [15:0]        mul_b,
    input  logic               mul_done,
    input  logic [15:0]        mul_result,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t          state_reg;
    logic [IW-1:0]   rr_reg;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] grant_onehot;
    logic [NREQ-1:0] owner_onehot;
    logic [15:0]     a_arr [NREQ];
    logic [15:0]     b_arr [NREQ];
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic            zero_op;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]        = req_a[16*gi +: 16];
            assign b_arr[gi]        = req_b[16*gi +: 16];
            assign grant_onehot[gi] = grant_any && (grant_idx == IW'(gi));
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
        end
    endgenerate

    // First valid requester strictly after the last grant, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_reg) + k) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    assign sel_a   = a_arr[grant_idx];
    assign sel_b   = b_arr[grant_idx];
    assign zero_op = (sel_a[14:0] == 15'd0) || (sel_b[14:0] == 15'd0);

    // Accept is combinational but suppressed while reset is asserted.
    assign req_ready = (state_reg == IDLE && rst_n) ? grant_onehot : '0;

`ifdef LFPM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_reg;
    logic          rsp_err_reg;
    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_reg       <= IW'(NREQ - 1);
            owner_reg    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            busy         <= 1'b0;
`ifdef LFPM_TIMEOUT_EN
            wait_cnt_reg <= '0;
            rsp_err_reg  <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        rr_reg    <= grant_idx;
                        owner_reg <= grant_idx;
                        busy      <= 1'b1;
                        if (zero_op) begin
                            rsp_data  <= {sel_a[15] ^ sel_b[15], 15'd0};
                            rsp_valid <= grant_onehot;
`ifdef LFPM_TIMEOUT_EN
                            rsp_err_reg <= 1'b0;
`endif
                            state_reg <= RESPOND;
                        end else begin
                            mul_a     <= sel_a;
                            mul_b     <= sel_b;
                            mul_start <= 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
`ifdef LFPM_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the expiry cycle still yields the real product.
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_valid <= owner_onehot;
`ifdef LFPM_TIMEOUT_EN
                        rsp_err_reg <= 1'b0;
`endif
                        state_reg <= RESPOND;
                    end
`ifdef LFPM_TIMEOUT_EN
                    else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data    <= 16'h7E00;
                        rsp_err_reg <= 1'b1;
                        rsp_valid   <= owner_onehot;
                        state_reg   <= RESPOND;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfpm_share_arbiter.sv
// Directed bench for lfpm_share_arbiter: reset, core path, zero bypass, round-robin, backpressure, async reset.
module tb_lfpm_share_arbiter;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [15:0]        rsp_data;
    logic               rsp_err;
    logic               mul_start;
    logic [15:0]        mul_a;
    logic [15:0]        mul_b;
    logic               mul_done;
    logic [15:0]        mul_result;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    lfpm_share_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] oh;
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_a      = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
        req_b      = {4{16'h4000}};
        rsp_ready  = 4'b1111;
        mul_done   = 1'b0;
        mul_result = 16'h0;

        // Reset state, with every requester already valid
        nxt(); nxt();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        chk("rst_mul_start", 32'(mul_start), 32'h0);
        chk("rst_mul_a",     32'(mul_a),     32'h0);
        chk("rst_mul_b",     32'(mul_b),     32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        rst_n = 1'b1;
        #1;

        // Round-robin with all valid: grants 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            oh = 4'b0001 << (i % 4);
            chk("rr_grant", 32'(req_ready), 32'(oh));
            $display("rr op %0d: req_ready=%b", i, req_ready);
            nxt();
            chk("rr_start", 32'(mul_start), 32'h1);
            chk("rr_mul_a", 32'(mul_a), 32'h3C00 + 32'(i % 4));
            nxt();
            mul_done = 1'b1; mul_result = 16'h1000 + 16'(i);
            nxt();
            mul_done = 1'b0;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("rr_rsp_data",  32'(rsp_data),  32'h1000 + 32'(i));
            nxt(); #1;
        end

        // Single op on requester 2, done three cycles after start
        req_valid = 4'b0100; rsp_ready = 4'b0000;
        req_a[47:32] = 16'h3C00; req_b[47:32] = 16'h4000;
        #1;
        chk("so_grant", 32'(req_ready), 32'h4);
        nxt();
        req_valid = 4'b0000;
        chk("so_start", 32'(mul_start), 32'h1);
        chk("so_mul_a", 32'(mul_a), 32'h3C00);
        chk("so_mul_b", 32'(mul_b), 32'h4000);
        chk("so_busy",  32'(busy), 32'h1);
        chk("so_ready_busy", 32'(req_ready), 32'h0);
        nxt();
        chk("so_start_pulse", 32'(mul_start), 32'h0);
        nxt(); nxt();
        mul_done = 1'b1; mul_result = 16'h4000;
        chk("so_early_valid", 32'(rsp_valid), 32'h0);
        nxt();
        mul_done = 1'b0;
        chk("so_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("so_rsp_data",  32'(rsp_data),  32'h4000);
        chk("so_rsp_err",   32'(rsp_err),   32'h0);
        chk("so_mul_a_hold", 32'(mul_a),    32'h3C00);
        $display("single op: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);
        rsp_ready = 4'b0100;
        nxt();
        chk("so_done_valid", 32'(rsp_valid), 32'h0);
        chk("so_done_busy",  32'(busy), 32'h0);

        // Zero bypass on requester 0: -0 * 3.0 = -0
        req_valid = 4'b0001; rsp_ready = 4'b0000;
        req_a[15:0] = 16'h8000; req_b[15:0] = 16'h4200;
        #1;
        chk("zb_grant", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0000;
        chk("zb_no_start", 32'(mul_start), 32'h0);
        chk("zb_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("zb_rsp_data",  32'(rsp_data),  32'h8000);
        chk("zb_busy", 32'(busy), 32'h1);
        $display("zero bypass: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);
        rsp_ready = 4'b0001;
        nxt();
        chk("zb_done_valid", 32'(rsp_valid), 32'h0);

        // Backpressure on requester 1; non-owners assert rsp_ready
        req_valid = 4'b1111; rsp_ready = 4'b1101;
        req_a[31:16] = 16'h0000; req_b[31:16] = 16'hC000;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        for (int i = 0; i < 10; i++) begin
            nxt();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("bp_rsp_data",  32'(rsp_data),  32'h8000);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        $display("backpressure: held 10 cycles rsp_valid=%b", rsp_valid);
        req_valid = 4'b0000; rsp_ready = 4'b1111;
        nxt();
        chk("bp_rel_busy",  32'(busy), 32'h0);
        chk("bp_rel_valid", 32'(rsp_valid), 32'h0);

        // Reset during WAIT with a denormal operand (must go to the core)
        req_valid = 4'b1000;
        req_a[63:48] = 16'h0001; req_b[63:48] = 16'h3C00;
        #1;
        chk("mr_grant", 32'(req_ready), 32'h8);
        nxt();
        req_valid = 4'b0000;
        chk("mr_start", 32'(mul_start), 32'h1);
        chk("mr_mul_a", 32'(mul_a), 32'h0001);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("mr_async_busy",  32'(busy),  32'h0);
        chk("mr_async_mul_a", 32'(mul_a), 32'h0);
        chk("mr_async_mul_b", 32'(mul_b), 32'h0);
        nxt();
        rst_n = 1'b1;
        mul_done = 1'b1; mul_result = 16'h5555;
        nxt();
        mul_done = 1'b0;
        chk("mr_late_valid", 32'(rsp_valid), 32'h0);
        chk("mr_late_busy",  32'(busy), 32'h0);
        chk("mr_late_data",  32'(rsp_data), 32'h0);
        nxt();
        chk("mr_late_valid2", 32'(rsp_valid), 32'h0);
        $display("mid-op reset: rsp_valid=%b busy=%b", rsp_valid, busy);

`ifdef LFPM_TIMEOUT_EN
        // Watchdog: expiry on the 8th WAIT cycle, then done on that same cycle
        for (int t = 0; t < 2; t++) begin
            req_valid = 4'b0001; rsp_ready = 4'b1111;
            req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4400;
            #1;
            chk("to_grant", 32'(req_ready), 32'h1);
            nxt();
            req_valid = 4'b0000;
            for (int w = 1; w <= 8; w++) begin
                nxt();
                if (t == 1 && w == 8) begin
                    mul_done = 1'b1; mul_result = 16'h4400;
                end
                chk("to_wait_valid", 32'(rsp_valid), 32'h0);
            end
            nxt();
            mul_done = 1'b0;
            chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("to_rsp_data",  32'(rsp_data),  (t == 0) ? 32'h7E00 : 32'h4400);
            chk("to_rsp_err",   32'(rsp_err),   (t == 0) ? 32'h1 : 32'h0);
            $display("timeout run %0d: rsp_data=%h rsp_err=%b", t, rsp_data, rsp_err);
            nxt();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
